fetch_decode_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register feeding the immediate extender.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/if_skid_buffer.sv | 33 +++
 rtl/fetch_decode_stage.sv | 116 +++++++++++
 tb/tb_fetch_decode_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: immediate-source encodings, the NOP word
// and the fetch FSM state type.
package cpu_pkg;

  localparam logic [1:0]  IMM_SRC_DP  = 2'b00;
  localparam logic [1:0]  IMM_SRC_MEM = 2'b01;
  localparam logic [1:0]  IMM_SRC_BR  = 2'b10;

  // mov r0,r0
  localparam logic [31:0] NOP_INSTR   = 32'hE1A0_0000;

  typedef enum logic {
    S_REQ,
    S_HOLD
  } fetchState_e;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {instr,pc} holding register used when decode stalls mid-fetch.
// Only the full flag is reset; the payload is meaningless while empty.
module if_skid_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      instrOut <= instrIn;
      pcOut    <= pcIn;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch with IF/ID register and one-entry skid buffer; decodes the
// immediate field and immediate-source select for the extender.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d,
  output logic [23:0] imm_value_d,
  output logic [1:0]  imm_src_d
);
  import cpu_pkg::*;

  fetchState_e state;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic [31:0] skidInstr;
  logic [31:0] skidPc;
  logic        skidFull;
  logic        skidLoad;
  logic        skidUnload;

  assign skidLoad   = (state == S_REQ) && imem_valid && stall_d && !branch_taken;
  assign skidUnload = (state == S_HOLD) && !stall_d && !branch_taken;

  if_skid_buffer skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skidLoad),
    .unload   (skidUnload),
    .clear    (branch_taken),
    .instrIn  (imem_rdata),
    .pcIn     (pcF),
    .instrOut (skidInstr),
    .pcOut    (skidPc),
    .full     (skidFull)
  );

  // fetch -> IF/ID boundary; a redirect overrides stall and any response
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_REQ;
      pcF    <= RESET_PC;
      validD <= 1'b0;
      instrD <= NOP_INSTR;
      pcD    <= 32'h0;
    end else if (branch_taken) begin
      state  <= S_REQ;
      pcF    <= branch_target & ~32'd3;
      validD <= 1'b0;
      instrD <= NOP_INSTR;
    end else begin
      case (state)
        S_REQ: begin
          if (!stall_d) begin
            if (imem_valid) begin
              instrD <= imem_rdata;
              pcD    <= pcF;
              validD <= 1'b1;
              pcF    <= pcF + 32'd4;
            end else begin
              instrD <= NOP_INSTR;
              validD <= 1'b0;
            end
          end else if (imem_valid) begin
            pcF   <= pcF + 32'd4;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_d && skidFull) begin
            instrD <= skidInstr;
            pcD    <= skidPc;
            validD <= 1'b1;
            state  <= S_REQ;
          end else if (!stall_d) begin
            state  <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign imem_req    = (state == S_REQ) && !reset;
  assign imem_addr   = pcF;
  assign instr_d     = instrD;
  assign pc_d        = pcD;
  assign pc_plus8_d  = pcD + 32'd8;
  assign valid_d     = validD;
  assign imm_value_d = instrD[23:0];

  always_comb begin
    imm_src_d = IMM_SRC_DP;
    case (instrD[27:26])
      2'b00:   imm_src_d = IMM_SRC_DP;
      2'b01:   imm_src_d = IMM_SRC_MEM;
      2'b10:   imm_src_d = IMM_SRC_BR;
      default: imm_src_d = IMM_SRC_DP;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: hand-computed expectations for
// streaming fetch, stall/skid, branch redirect, bubbles, PC wrap and reset.
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_d;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus8_d;
  logic        valid_d;
  logic [23:0] imm_value_d;
  logic [1:0]  imm_src_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall_d       (stall_d),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pc_plus8_d    (pc_plus8_d),
    .valid_d       (valid_d),
    .imm_value_d   (imm_value_d),
    .imm_src_d     (imm_src_d)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic b,
                       input logic [31:0] t);
    imem_valid    = v;
    imem_rdata    = d;
    stall_d       = s;
    branch_taken  = b;
    branch_target = t;
  endtask

  task automatic checkIfId(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc);
    checkVal({tag, ".valid"}, {31'b0, valid_d}, {31'b0, v});
    checkVal({tag, ".instr"}, instr_d, ins);
    if (v) checkVal({tag, ".pc"}, pc_d, pc);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    // reset state
    checkVal("rst.valid", {31'b0, valid_d}, 32'h0);
    checkVal("rst.instr", instr_d, NOP);
    checkVal("rst.pc_d", pc_d, 32'h0);
    checkVal("rst.pc8", pc_plus8_d, 32'h8);
    checkVal("rst.immv", {8'h0, imm_value_d}, 32'h00A0_0000);
    checkVal("rst.imms", {30'b0, imm_src_d}, 32'h0);
    checkVal("rst.addr", imem_addr, 32'h0);
    checkVal("rst.req", {31'b0, imem_req}, 32'h0);

    // 1: streaming fetch
    reset = 1'b0;
    drive(1'b1, 32'hE3A0_1005, 1'b0, 1'b0, 32'h0);
    #1;
    checkVal("t1.req0", {31'b0, imem_req}, 32'h1);
    step();
    checkIfId("t1.a", 1'b1, 32'hE3A0_1005, 32'h0);
    checkVal("t1.a.imms", {30'b0, imm_src_d}, 32'h0);
    checkVal("t1.a.immv", {8'h0, imm_value_d}, 32'h00A0_1005);
    checkVal("t1.a.pc8", pc_plus8_d, 32'h8);
    checkVal("t1.a.addr", imem_addr, 32'h4);
    drive(1'b1, 32'hE591_2004, 1'b0, 1'b0, 32'h0);
    step();
    checkIfId("t1.b", 1'b1, 32'hE591_2004, 32'h4);
    checkVal("t1.b.imms", {30'b0, imm_src_d}, 32'h1);
    checkVal("t1.b.immv", {8'h0, imm_value_d}, 32'h0091_2004);
    drive(1'b1, 32'hEA00_0002, 1'b0, 1'b0, 32'h0);
    step();
    checkIfId("t1.c", 1'b1, 32'hEA00_0002, 32'h8);
    checkVal("t1.c.imms", {30'b0, imm_src_d}, 32'h2);
    checkVal("t1.c.immv", {8'h0, imm_value_d}, 32'h0000_0002);
    drive(1'b1, 32'hEE00_0000, 1'b0, 1'b0, 32'h0);
    step();
    checkVal("t1.d.imms", {30'b0, imm_src_d}, 32'h0);
    checkVal("t1.d.addr", imem_addr, 32'h10);

    // 2: stall while a response arrives at 0x10
    drive(1'b1, 32'hE591_3008, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal($sformatf("t2.req%0d", i), {31'b0, imem_req}, 32'h0);
      checkIfId($sformatf("t2.hold%0d", i), 1'b1, 32'hEE00_0000, 32'hC);
      checkVal($sformatf("t2.addr%0d", i), imem_addr, 32'h14);
      drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkIfId("t2.unload", 1'b1, 32'hE591_3008, 32'h10);
    checkVal("t2.req", {31'b0, imem_req}, 32'h1);
    checkVal("t2.addr", imem_addr, 32'h14);
    drive(1'b1, 32'hE3A0_4001, 1'b0, 1'b0, 32'h0);
    step();
    checkIfId("t2.next", 1'b1, 32'hE3A0_4001, 32'h14);

    // 3: branch beats stall and a valid response
    drive(1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 32'h0000_0103);
    step();
    checkVal("t3.addr", imem_addr, 32'h100);
    checkIfId("t3.flush", 1'b0, NOP, 32'h0);
    checkVal("t3.req", {31'b0, imem_req}, 32'h1);
    drive(1'b1, 32'hE3A0_5003, 1'b0, 1'b0, 32'h0);
    step();
    checkIfId("t3.tgt", 1'b1, 32'hE3A0_5003, 32'h100);
    // branch while holding a skid entry
    drive(1'b1, 32'hBAD0_0002, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
    step();
    checkVal("t3.hold.addr", imem_addr, 32'h200);
    checkIfId("t3.hold.flush", 1'b0, NOP, 32'h0);

    // 4: two bubbles
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      checkIfId($sformatf("t4.bub%0d", i), 1'b0, NOP, 32'h0);
      checkVal($sformatf("t4.addr%0d", i), imem_addr, 32'h200);
      checkVal($sformatf("t4.req%0d", i), {31'b0, imem_req}, 32'h1);
    end

    // 5: PC wrap
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step();
    checkVal("t5.addr0", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 32'hEA00_0010, 1'b0, 1'b0, 32'h0);
    step();
    checkIfId("t5", 1'b1, 32'hEA00_0010, 32'hFFFF_FFFC);
    checkVal("t5.pc8", pc_plus8_d, 32'h4);
    checkVal("t5.addr", imem_addr, 32'h0);

    // 6: reset in S_HOLD drops the skid entry
    drive(1'b1, 32'hE3A0_6006, 1'b1, 1'b0, 32'h0);
    step();
    checkVal("t6.hold.req", {31'b0, imem_req}, 32'h0);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    checkVal("t6.addr", imem_addr, 32'h0);
    checkIfId("t6.rst", 1'b0, NOP, 32'h0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    checkVal("t6.req", {31'b0, imem_req}, 32'h1);
    step();
    checkIfId("t6.noskid", 1'b0, NOP, 32'h0);
    checkVal("t6.addr2", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
